// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: DLFloat widths, constants, word struct, and the shared round/saturate/flush helper.
// DLF_MAC_RNE_EN selects round-to-nearest-even; otherwise rounding truncates toward zero.
package dlfloat_pkg;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_W = 1 + DLF_EXP_W + DLF_MAN_W;
  localparam int DLF_BIAS = (1 << (DLF_EXP_W - 1)) - 1;
  localparam int DLF_EXP_MAX = (1 << DLF_EXP_W) - 1;
  localparam logic [DLF_W-2:0] DLF_MAX_MAG = '1;
  localparam int DLF_XW = DLF_MAN_W + 4;
  typedef struct packed {
    logic sign;
    logic [DLF_EXP_W-1:0] exp;
    logic [DLF_MAN_W-1:0] mant;
  } dlf_t;
  function automatic logic is_zero(input dlf_t x);
    return x.exp == '0;
  endfunction
  // m = {hidden 1, mantissa, guard, round, sticky}; e is the biased exponent of the hidden bit
  function automatic dlf_t round_pack(input logic s, input int e, input logic [DLF_XW-1:0] m);
    logic [DLF_MAN_W+1:0] r;
    int ex;
    r = {1'b0, m[DLF_XW-1:3]};
`ifdef DLF_MAC_RNE_EN
    r = r + {{(DLF_MAN_W + 1){1'b0}}, m[2] & (m[1] | m[0] | m[3])};
`endif
    ex = r[DLF_MAN_W+1] ? e + 1 : e;
    if (ex > DLF_EXP_MAX) return {s, DLF_MAX_MAG};
    if (ex < 1) return '0;
    return {s, ex[DLF_EXP_W-1:0], r[DLF_MAN_W+1] ? r[DLF_MAN_W:1] : r[DLF_MAN_W-1:0]};
  endfunction
endpackage

// File: rtl/dlfloat_add_rnd.sv
// dlfloat_add_rnd: combinational DLFloat add/subtract with alignment, normalisation and one rounding.
// Rounding mode follows DLF_MAC_RNE_EN through the package helper.
module dlfloat_add_rnd
  import dlfloat_pkg::*;
(
  input  dlf_t a_i,
  input  dlf_t b_i,
  output dlf_t y_o
);
  localparam int SW = DLF_MAN_W + 5;
  dlf_t x, y, r;
  logic swap;
  logic [SW-1:0] sx, sy, sum;
  int d, e;
  always_comb begin
    swap = a_i[DLF_W-2:0] < b_i[DLF_W-2:0];
    x = swap ? b_i : a_i;
    y = swap ? a_i : b_i;
    d = int'(x.exp) - int'(y.exp);
    sx = {2'b01, x.mant, 3'b000};
    sy = {2'b01, y.mant, 3'b000};
    for (int i = 0; i < SW; i++) if (i < d) sy = {1'b0, sy[SW-1:2], sy[1] | sy[0]};
    sum = (x.sign == y.sign) ? sx + sy : sx - sy;
    e = int'(x.exp);
    if (sum[SW-1]) r = round_pack(x.sign, e + 1, {sum[SW-1:4], sum[3], sum[2], |sum[1:0]});
    else begin
      for (int i = 0; i < SW; i++) if (!sum[SW-2] && sum != '0) begin
        sum = sum << 1;
        e = e - 1;
      end
      r = round_pack(x.sign, e, sum[SW-2:0]);
    end
    y_o = is_zero(a_i) ? b_i : is_zero(b_i) ? a_i : (sum == '0) ? '0 : r;
  end
endmodule

// File: rtl/dlfloat_mac_stream.sv
// dlfloat_mac_stream: 3-stage streaming DLFloat dot-product engine (operand, product, accumulate).
// Build macro DLF_MAC_RNE_EN selects round-to-nearest-even instead of truncation.
module dlfloat_mac_stream
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int CNT_W = 8,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count
);
  localparam int PW = 2 * (DLF_MAN_W + 1);
  logic adv, s1_v_q, s1_last_q, s2_v_q, s2_last_q, out_vld_q;
  dlf_t s1_a_q, s1_b_q, prod_q, prod_d, acc_q, sum, out_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q;
  logic [PW-1:0] p, n;
  int e;
  assign adv = !out_vld_q || out_ready;
  assign in_ready = adv && !clear;
  assign out_valid = out_vld_q;
  assign out_data = out_data_q;
  assign out_count = out_cnt_q;
  dlfloat_add_rnd u_add (.a_i(acc_q), .b_i(prod_q), .y_o(sum));
  // exact product is normalised to {hidden, mant, guard, round, sticky} before the single rounding
  always_comb begin
    p = PW'({1'b1, s1_a_q.mant}) * PW'({1'b1, s1_b_q.mant});
    n = p[PW-1] ? p : p << 1;
    e = int'(s1_a_q.exp) + int'(s1_b_q.exp) - DLF_BIAS + (p[PW-1] ? 1 : 0);
    prod_d = (is_zero(s1_a_q) || is_zero(s1_b_q)) ? '0 :
      round_pack(s1_a_q.sign ^ s1_b_q.sign, e,
                 {n[PW-1:DLF_MAN_W+1], n[DLF_MAN_W], n[DLF_MAN_W-1], |n[DLF_MAN_W-2:0]});
    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {s1_v_q, s2_v_q, out_vld_q, acc_q, cnt_q, out_data_q, out_cnt_q} <= '0;
    else if (clear) {s1_v_q, s2_v_q, out_vld_q, acc_q, cnt_q, out_data_q, out_cnt_q} <= '0;
    else if (adv) begin
      s1_v_q <= in_valid;
      s1_a_q <= in_a;
      s1_b_q <= in_b;
      s1_last_q <= in_last;
      s2_v_q <= s1_v_q;
      s2_last_q <= s1_last_q;
      prod_q <= prod_d;
      out_vld_q <= s2_v_q && s2_last_q;
      if (s2_v_q) begin
        acc_q <= s2_last_q ? '0 : sum;
        cnt_q <= s2_last_q ? '0 : cnt_d;
        if (s2_last_q) begin
          out_data_q <= sum;
          out_cnt_q <= cnt_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_dlfloat_mac_stream.sv
// tb_dlfloat_mac_stream: directed vectors with hand-computed DLFloat results for dlfloat_mac_stream.
module tb_dlfloat_mac_stream;
  logic clk = 0, rst, clear, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_data;
  logic [7:0] out_count;
  int n_chk = 0, n_bad = 0;
  dlfloat_mac_stream dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic l);
    int t = 0;
    in_valid = 1; in_a = a; in_b = b; in_last = l;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("send_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    in_valid = 0; in_last = 0;
  endtask
  task automatic wait_valid(input string tag);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk(tag, out_valid, 1);
  endtask
  task automatic get_result(input string tag, input logic [15:0] d, input logic [7:0] c);
    wait_valid({tag, "_valid"});
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, out_count, c);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1; clear = 0; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    // 1*2 + 1.5*2 + 3*1 = 8, with latency k+2
    send(16'h3E00, 16'h4000, 0);
    send(16'h3F00, 16'h4000, 0);
    send(16'h4100, 16'h3E00, 1);
    idle();
    chk("lat_k0", out_valid, 0);
    @(negedge clk);
    chk("lat_k1", out_valid, 0);
    @(negedge clk);
    chk("lat_k2", out_valid, 1);
    chk("dot3_data", out_data, 16'h4400);
    chk("dot3_count", out_count, 3);
    @(negedge clk);
    send(16'h4000, 16'h3F00, 0);
    send(16'hBE00, 16'h4100, 1);
    idle();
    get_result("cancel", 16'h0000, 2);
    send(16'h0000, 16'h4100, 1);
    idle();
    get_result("zero_op", 16'h0000, 1);
    send(16'h3E00, 16'h3E00, 1);
    idle();
    get_result("acc_cleared", 16'h3E00, 1);
    send(16'h7FFF, 16'h7FFF, 1);
    idle();
    get_result("ovf_pos", 16'h7FFF, 1);
    send(16'hFFFF, 16'h7FFF, 1);
    idle();
    get_result("ovf_neg", 16'hFFFF, 1);
    send(16'h3E01, 16'h3F01, 1);
    idle();
`ifdef DLF_MAC_RNE_EN
    get_result("round", 16'h3F03, 1);
`else
    get_result("round", 16'h3F02, 1);
`endif
    // back-pressure: 2.0 then 4+1 = 5.0 queued behind it
    out_ready = 0;
    send(16'h3E00, 16'h4000, 1);
    send(16'h4000, 16'h4000, 0);
    send(16'h3E00, 16'h3E00, 1);
    idle();
    wait_valid("bp_first_valid");
    chk("bp_ready_low", in_ready, 0);
    chk("bp_data", out_data, 16'h4000);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 16'h4000);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1;
    get_result("bp_a", 16'h4000, 1);
    get_result("bp_b", 16'h4280, 2);
    // clear mid-vector; the pair offered during clear must be refused
    send(16'h4000, 16'h4000, 0);
    send(16'h4000, 16'h4000, 0);
    clear = 1; in_valid = 1; in_a = 16'h3E00; in_b = 16'h3E00; in_last = 1;
    #1 chk("clear_ready", in_ready, 0);
    @(negedge clk);
    clear = 0;
    idle();
    repeat (4) @(negedge clk);
    chk("clear_no_out", out_valid, 0);
    send(16'h3E00, 16'h4000, 1);
    idle();
    get_result("after_clear", 16'h4000, 1);
    // count saturation at 255
    for (int i = 0; i < 299; i++) send(16'h0000, 16'h0000, 0);
    send(16'h3E00, 16'h3E00, 1);
    idle();
    get_result("cnt_sat", 16'h3E00, 255);
    // async reset in the middle of a stall
    out_ready = 0;
    send(16'h3E00, 16'h4000, 1);
    send(16'h4000, 16'h4000, 0);
    idle();
    wait_valid("stall_valid");
    rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_count", out_count, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    repeat (5) @(negedge clk);
    chk("arst_no_partial", out_valid, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
